// File: rtl/prio_enc_rr.sv
// Registered priority encoder with MSB-first, LSB-first and round-robin search.
// One-deep valid/ready output stage; rr_ptr advances past each round-robin grant.
module prio_enc_rr #(
    parameter  int WIDTH = 8,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_req,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [WIDTH-1:0] out_onehot,
    output logic             out_found,
    output logic [IDX_W-1:0] rr_ptr
);

    logic             accept;
    logic             valid_q, valid_d;
    logic             found_q, found_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0] onehot_q, onehot_d;
    logic [IDX_W:0]   rr_j;

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        found_d = |in_req;
        idx_d   = '0;
        rr_j    = '0;
        unique case (1'b1)
            in_mode == 2'b00: begin
                for (int i = 0; i < WIDTH; i++)
                    if (in_req[i]) idx_d = IDX_W'(i);
            end
            in_mode == 2'b01: begin
                for (int i = WIDTH - 1; i >= 0; i--)
                    if (in_req[i]) idx_d = IDX_W'(i);
            end
            in_mode[1]: begin
                // Walk offsets downward so the nearest hit from ptr wins.
                for (int k = WIDTH - 1; k >= 0; k--) begin
                    rr_j = {1'b0, ptr_q} + (IDX_W+1)'(k);
                    if (rr_j >= (IDX_W+1)'(WIDTH))
                        rr_j = rr_j - (IDX_W+1)'(WIDTH);
                    if (in_req[rr_j[IDX_W-1:0]])
                        idx_d = rr_j[IDX_W-1:0];
                end
            end
            default: ;
        endcase
        onehot_d = found_d ? (WIDTH'(1) << idx_d) : '0;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept && in_mode[1] && found_d)
            ptr_d = (idx_d == IDX_W'(WIDTH - 1)) ? '0 : idx_d + 1'b1;
        valid_d = valid_q;
        if (accept)
            valid_d = 1'b1;
        else if (valid_q && out_ready)
            valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            found_q  <= 1'b0;
            idx_q    <= '0;
            onehot_q <= '0;
            ptr_q    <= '0;
        end else begin
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            if (accept) begin
                found_q  <= found_d;
                idx_q    <= idx_d;
                onehot_q <= onehot_d;
            end
        end
    end

    assign out_valid  = valid_q;
    assign out_found  = found_q;
    assign out_idx    = idx_q;
    assign out_onehot = onehot_q;
    assign rr_ptr     = ptr_q;

endmodule

// File: tb/tb_prio_enc_rr.sv
// Scoreboard bench for prio_enc_rr: WIDTH=8 main instance, WIDTH=5 wrap instance.
// Directed vectors push expected results; monitors pop on each output handshake.
module tb_prio_enc_rr;

    typedef struct {
        int         idx;
        logic [7:0] oh;
        logic       found;
        int         ptr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0, out_ready = 1'b1;
    logic [7:0] in_req = '0;
    logic [1:0] in_mode = '0;
    logic       in_ready, out_valid, out_found;
    logic [2:0] out_idx, rr_ptr;
    logic [7:0] out_onehot;

    logic       in_valid5 = 1'b0;
    logic [4:0] in_req5 = '0;
    logic [1:0] in_mode5 = '0;
    logic       in_ready5, out_valid5, out_found5;
    logic [2:0] out_idx5, rr_ptr5;
    logic [4:0] out_onehot5;

    exp_t q[$];
    exp_t q5[$];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    prio_enc_rr #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_req(in_req), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx), .out_onehot(out_onehot),
        .out_found(out_found), .rr_ptr(rr_ptr)
    );

    prio_enc_rr #(.WIDTH(5)) dut5 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid5), .in_ready(in_ready5),
        .in_req(in_req5), .in_mode(in_mode5),
        .out_valid(out_valid5), .out_ready(1'b1),
        .out_idx(out_idx5), .out_onehot(out_onehot5),
        .out_found(out_found5), .rr_ptr(rr_ptr5)
    );

    task automatic chk(input string n, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", n, got, exp, $time);
        end
    endtask

    function automatic exp_t mk(input int i, input logic f, input int p);
        exp_t e;
        logic [7:0] one;
        one = 8'd1;
        e.idx = i;
        e.found = f;
        e.oh = f ? (one << i) : 8'h00;
        e.ptr = p;
        return e;
    endfunction

    // Monitors: compare on every output handshake
    int stall = 0;
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            stall = 0;
            if (q.size() == 0) begin
                chk("unexpected_out", 32'(out_idx), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("idx", 32'(out_idx), 32'(e.idx));
                chk("onehot", 32'(out_onehot), 32'(e.oh));
                chk("found", 32'(out_found), 32'(e.found));
                chk("ptr", 32'(rr_ptr), 32'(e.ptr));
            end
        end else if (q.size() != 0 && out_ready) begin
            stall++;
            if (stall > 100) begin
                chk("out_timeout", 32'(q.size()), 32'd0);
                q.delete();
                stall = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid5) begin
            if (q5.size() == 0) begin
                chk("w5_unexpected_out", 32'(out_idx5), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q5.pop_front();
                chk("w5_idx", 32'(out_idx5), 32'(e.idx));
                chk("w5_onehot", 32'({3'b000, out_onehot5}), 32'(e.oh));
                chk("w5_found", 32'(out_found5), 32'(e.found));
                chk("w5_ptr", 32'(rr_ptr5), 32'(e.ptr));
            end
        end
    end

    task automatic send(input logic [7:0] r, input logic [1:0] m,
                        input int ei, input logic ef, input int ep);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_req = r;
        in_mode = m;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        q.push_back(mk(ei, ef, ep));
        #1;
    endtask

    task automatic send5(input logic [4:0] r, input logic [1:0] m,
                         input int ei, input logic ef, input int ep);
        in_valid5 = 1'b1;
        in_req5 = r;
        in_mode5 = m;
        @(posedge clk);
        q5.push_back(mk(ei, ef, ep));
        #1;
        in_valid5 = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #3;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_ptr", 32'(rr_ptr), 32'd0);
        chk("rst_onehot", 32'(out_onehot), 32'd0);
        chk("rst_found", 32'(out_found), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fixed modes
        send(8'b0010_0110, 2'b00, 5, 1'b1, 0);
        send(8'b0010_0110, 2'b01, 1, 1'b1, 0);

        // Round-robin rotation, back to back
        for (int i = 0; i < 9; i++)
            send(8'hFF, (i % 2 == 0) ? 2'b10 : 2'b11, i % 8, 1'b1, (i + 1) % 8);

        // Bring ptr to 3, then empty vector holds it
        send(8'hFF, 2'b10, 1, 1'b1, 2);
        send(8'hFF, 2'b10, 2, 1'b1, 3);
        send(8'h00, 2'b10, 0, 1'b0, 3);
        send(8'h01, 2'b11, 0, 1'b1, 1);
        send(8'h00, 2'b00, 0, 1'b0, 1);

        // Backpressure then simultaneous drain + accept
        idle();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_req = 8'h80;
        in_mode = 2'b01;
        @(posedge clk);
        q.push_back(mk(7, 1'b1, 1));
        #1;
        in_req = 8'h04;
        in_mode = 2'b10;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_ready", 32'(in_ready), 32'd0);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_idx", 32'(out_idx), 32'd7);
            chk("bp_onehot", 32'(out_onehot), 32'h80);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        q.push_back(mk(2, 1'b1, 3));
        #1;
        chk("bp_valid_kept", 32'(out_valid), 32'd1);
        chk("bp_new_idx", 32'(out_idx), 32'd2);

        // Bring ptr to 6, hold a result, reset mid-stream
        send(8'hFF, 2'b10, 3, 1'b1, 4);
        send(8'h20, 2'b10, 5, 1'b1, 6);
        idle();
        out_ready = 1'b0;
        send(8'h01, 2'b00, 0, 1'b1, 6);
        in_valid = 1'b0;
        #1;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        chk("pre_rst_ptr", 32'(rr_ptr), 32'd6);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_ptr", 32'(rr_ptr), 32'd0);
        chk("arst_idx", 32'(out_idx), 32'd0);
        chk("arst_found", 32'(out_found), 32'd0);
        chk("arst_ready", 32'(in_ready), 32'd1);
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(8'hC1, 2'b10, 0, 1'b1, 1);
        idle();

        // WIDTH=5 wrap
        send5(5'b01000, 2'b10, 3, 1'b1, 4);
        send5(5'b10001, 2'b11, 4, 1'b1, 0);
        send5(5'b10001, 2'b10, 0, 1'b1, 1);
        send5(5'b00110, 2'b00, 2, 1'b1, 1);
        send5(5'b00110, 2'b01, 1, 1'b1, 1);
        idle();

        for (int t = 0; t < 100; t++) begin
            if (q.size() == 0 && q5.size() == 0) break;
            @(posedge clk);
        end
        if (q.size() != 0 || q5.size() != 0)
            chk("drain_timeout", 32'(q.size() + q5.size()), 32'd0);
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
